// File: rtl/stratix_ddio_in_bus.sv
// -----------------------------------------------------------------------------
// stratix_ddio_in_bus
//
// DDR input capture for a source-synchronous receive bus. Each lane is sampled
// on the rising edge (h beat) and on the falling edge (l beat). Both beats are
// realigned to the rising edge. An optional 2:1 gearbox packs two consecutive
// DDR pairs into one 4*WIDTH word. A one-pair bitslip shifts the word boundary.
//
// Parameters
//   WIDTH       number of DDR lanes (1..64)
//   RESET_MODE  "clear" resets the data registers to all 0, "preset" to all 1
//   GEARBOX_EN  1 builds the gearbox; 0 holds word_out at the reset value
//               and keeps word_valid low
//
// Ports
//   clk          capture clock; rising edge = h beat, falling edge = l beat
//   areset       asynchronous reset, active high
//   clkena       capture enable, sampled on the rising edge
//   bitslip      one-cycle pulse; discards the next enabled pair
//   padio        pad data; this block only reads it and never drives it
//   dataout_h    rising-edge beat, aligned to the rising edge
//   dataout_l    falling-edge beat of the same pair, aligned to the rising edge
//   dataout_vld  dataout_h/l were updated this cycle
//   word_out     {l1,h1,l0,h0}; pair0 is the older pair
//   word_valid   one-cycle strobe; word_out was updated this cycle
// -----------------------------------------------------------------------------
module stratix_ddio_in_bus #(
    parameter int    WIDTH      = 8,
    parameter string RESET_MODE = "clear",
    parameter bit    GEARBOX_EN = 1'b1
) (
    input  logic               clk,
    input  logic               areset,
    input  logic               clkena,
    input  logic               bitslip,
    inout  wire  [WIDTH-1:0]   padio,
    output logic [WIDTH-1:0]   dataout_h,
    output logic [WIDTH-1:0]   dataout_l,
    output logic               dataout_vld,
    output logic [4*WIDTH-1:0] word_out,
    output logic               word_valid
);

    localparam logic             RST_BIT = (RESET_MODE == "preset");
    localparam logic [WIDTH-1:0] RST_VAL = {WIDTH{RST_BIT}};

    logic             ena_q;
    logic [WIDTH-1:0] cap_h;
    logic [WIDTH-1:0] cap_l;

    // Rising-edge capture. ena_q carries this edge's enable to the falling
    // edge and to the realignment stage on the next rising edge.
    // NOTE: every clocked register uses <= so that all flops sample their
    // inputs before any of them update, which keeps the pipeline order intact.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ena_q <= 1'b0;
            cap_h <= RST_VAL;
        end else begin
            ena_q <= clkena;
            if (clkena) begin
                cap_h <= padio;
            end
        end
    end

    // Falling-edge capture. This register is qualified by ena_q rather than by
    // clkena, so clkena only has to meet timing to the rising edge.
    always_ff @(negedge clk or posedge areset) begin
        if (areset) begin
            cap_l <= RST_VAL;
        end else if (ena_q) begin
            cap_l <= padio;
        end
    end

    // Realign both beats to the rising edge. The outputs hold while the
    // pair was not enabled.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            dataout_h   <= RST_VAL;
            dataout_l   <= RST_VAL;
            dataout_vld <= 1'b0;
        end else begin
            dataout_vld <= ena_q;
            if (ena_q) begin
                dataout_h <= cap_h;
                dataout_l <= cap_l;
            end
        end
    end

    generate
        if (GEARBOX_EN) begin : g_gearbox
            logic               phase;
            logic               slip_pend;
            logic [2*WIDTH-1:0] pair0;

            // pair0 gets a full reset so that a word never combines a pair
            // from before the reset with a pair from after it.
            always_ff @(posedge clk or posedge areset) begin
                if (areset) begin
                    phase      <= 1'b0;
                    slip_pend  <= 1'b0;
                    pair0      <= {2*WIDTH{RST_BIT}};
                    word_out   <= {4*WIDTH{RST_BIT}};
                    word_valid <= 1'b0;
                end else begin
                    word_valid <= 1'b0;
                    if (dataout_vld) begin
                        if (slip_pend) begin
                            // Drop this pair. A bitslip pulse that arrives
                            // while a slip is already pending is ignored.
                            slip_pend <= 1'b0;
                        end else begin
                            // The pair completes first; a bitslip pulse seen
                            // on the same edge applies to the next pair.
                            if (bitslip) begin
                                slip_pend <= 1'b1;
                            end
                            if (!phase) begin
                                pair0 <= {dataout_l, dataout_h};
                                phase <= 1'b1;
                            end else begin
                                word_out   <= {dataout_l, dataout_h, pair0};
                                word_valid <= 1'b1;
                                phase      <= 1'b0;
                            end
                        end
                    end else if (bitslip) begin
                        slip_pend <= 1'b1;
                    end
                end
            end
        end else begin : g_no_gearbox
            assign word_out   = {4*WIDTH{RST_BIT}};
            assign word_valid = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_stratix_ddio_in_bus.sv
// -----------------------------------------------------------------------------
// tb_stratix_ddio_in_bus
//
// Directed bench for stratix_ddio_in_bus with WIDTH=8, RESET_MODE="preset" and
// GEARBOX_EN=1. Each pair is presented as follows: the h beat is set before a
// rising edge, and the l beat is set just after that edge. Outputs are sampled
// one time unit after the falling edge, and word strobes are counted there.
// -----------------------------------------------------------------------------
module tb_stratix_ddio_in_bus;

    localparam int WIDTH = 8;

    logic               clk;
    logic               areset;
    logic               clkena;
    logic               bitslip;
    logic [WIDTH-1:0]   pad_drv;
    wire  [WIDTH-1:0]   padio;
    logic [WIDTH-1:0]   dataout_h;
    logic [WIDTH-1:0]   dataout_l;
    logic               dataout_vld;
    logic [4*WIDTH-1:0] word_out;
    logic               word_valid;

    int unsigned n_checks;
    int unsigned n_fails;
    int unsigned strobe_cnt;
    logic [31:0] last_word;

    assign padio = pad_drv;

    stratix_ddio_in_bus #(
        .WIDTH      (WIDTH),
        .RESET_MODE ("preset"),
        .GEARBOX_EN (1'b1)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .clkena      (clkena),
        .bitslip     (bitslip),
        .padio       (padio),
        .dataout_h   (dataout_h),
        .dataout_l   (dataout_l),
        .dataout_vld (dataout_vld),
        .word_out    (word_out),
        .word_valid  (word_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called one time unit after a falling edge. Drives one DDR pair, with an
    // optional bitslip pulse sampled on the same rising edge, and returns one
    // time unit after the following falling edge. It records any word strobe.
    task automatic pair(input logic [7:0] h, input logic [7:0] l, input logic ena, input logic slip);
        pad_drv = h;
        clkena  = ena;
        bitslip = slip;
        @(posedge clk);
        #1;
        pad_drv = l;
        bitslip = 1'b0;
        @(negedge clk);
        #1;
        if (word_valid === 1'b1) begin
            strobe_cnt++;
            last_word = word_out;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pair(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset is asserted between clock edges. The outputs must reach the
    // preset value with no clock edge occurring.
    task automatic do_reset(input string tag);
        areset = 1'b1;
        #1;
        check({tag, "_h"},    {24'h0, dataout_h},  32'h0000_00FF);
        check({tag, "_l"},    {24'h0, dataout_l},  32'h0000_00FF);
        check({tag, "_vld"},  {31'h0, dataout_vld}, 32'h0);
        check({tag, "_word"}, word_out,            32'hFFFF_FFFF);
        check({tag, "_wvld"}, {31'h0, word_valid}, 32'h0);
        #1;
        areset = 1'b0;
        strobe_cnt = 0;
        last_word  = '0;
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        strobe_cnt = 0;
        last_word  = '0;
        areset     = 1'b1;
        clkena     = 1'b0;
        bitslip    = 1'b0;
        pad_drv    = '0;
        repeat (2) @(negedge clk);
        #1;
        areset = 1'b0;

        // T2: DDR capture is presented on the rising edge after F(0).
        pair(8'hA5, 8'h3C, 1'b1, 1'b0);
        pair(8'h00, 8'h00, 1'b0, 1'b0);
        check("t2_h",   {24'h0, dataout_h},   32'h0000_00A5);
        check("t2_l",   {24'h0, dataout_l},   32'h0000_003C);
        check("t2_vld", {31'h0, dataout_vld}, 32'h1);
        idle(1);
        check("t2_vld_drop", {31'h0, dataout_vld}, 32'h0);

        // T1: an asynchronous reset in the middle of a run.
        do_reset("t1_rst");

        // T3: the gearbox packs two pairs.
        pair(8'h11, 8'h22, 1'b1, 1'b0);
        pair(8'h33, 8'h44, 1'b1, 1'b0);
        idle(2);
        check("t3_strobe_now", {31'h0, word_valid}, 32'h1);
        check("t3_word_now",   word_out,            32'h4433_2211);
        idle(3);
        check("t3_strobe_cnt", strobe_cnt,          32'd1);
        check("t3_word",       last_word,           32'h4433_2211);
        check("t3_hold",       word_out,            32'h4433_2211);

        // T4: a clkena gap between the pairs.
        do_reset("t4_rst");
        pair(8'h11, 8'h22, 1'b1, 1'b0);
        pair(8'hFF, 8'hFF, 1'b0, 1'b0);
        pair(8'h33, 8'h44, 1'b1, 1'b0);
        check("t4_gap_vld", {31'h0, dataout_vld}, 32'h0);
        check("t4_gap_h",   {24'h0, dataout_h},   32'h0000_0011);
        check("t4_gap_l",   {24'h0, dataout_l},   32'h0000_0022);
        idle(5);
        check("t4_strobe_cnt", strobe_cnt, 32'd1);
        check("t4_word",       last_word,  32'h4433_2211);

        // T5: single bitslip. The pulse is seen on the edge where (11,22) is
        // stored, so the pair (33,44) is discarded.
        do_reset("t5_rst");
        pair(8'h11, 8'h22, 1'b1, 1'b0);
        pair(8'h33, 8'h44, 1'b1, 1'b0);
        pair(8'h55, 8'h66, 1'b1, 1'b1);
        idle(5);
        check("t5_strobe_cnt", strobe_cnt, 32'd1);
        check("t5_word",       last_word,  32'h6655_2211);

        // T5b: double pulse. The second pulse arrives while the slip is pending.
        do_reset("t5b_rst");
        pair(8'h11, 8'h22, 1'b1, 1'b0);
        pair(8'h33, 8'h44, 1'b1, 1'b0);
        pair(8'h55, 8'h66, 1'b1, 1'b1);
        pair(8'h00, 8'h00, 1'b0, 1'b1);
        idle(5);
        check("t5b_strobe_cnt", strobe_cnt, 32'd1);
        check("t5b_word",       last_word,  32'h6655_2211);

        // T6: reset after pair0 is stored drops it.
        do_reset("t6_rst0");
        pair(8'h11, 8'h22, 1'b1, 1'b0);
        idle(2);
        do_reset("t6_rst1");
        pair(8'h55, 8'h66, 1'b1, 1'b0);
        pair(8'h77, 8'h88, 1'b1, 1'b0);
        idle(5);
        check("t6_strobe_cnt", strobe_cnt, 32'd1);
        check("t6_word",       last_word,  32'h8877_6655);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
